// File: rtl/fifo_control_pkg.sv
// Shared constants for the 8-entry FIFO pointer/flag controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_control_pkg;

    // Memory address width; the FIFO depth follows from it.
    localparam int PTR_W    = 3;
    localparam int DEPTH    = 1 << PTR_W;

    // Default occupancy thresholds for the almost flags.
    localparam int AF_LEVEL = 6;
    localparam int AE_LEVEL = 2;

endpackage : fifo_control_pkg

// File: rtl/fifo_ptr_counter.sv
// Wrapping address counter used for the FIFO write and read pointers.
// Latency: advances one step on the clock edge after inc is seen high.
// Backpressure: none; the caller decides when to increment.
module fifo_ptr_counter #(
    parameter int ptr_width = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    output logic [ptr_width-1:0] ptr
);

    logic [ptr_width-1:0] ptr_q;
    logic [ptr_width-1:0] ptr_d;

    // Next pointer: natural binary wrap from all-ones back to zero.
    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + ptr_width'(1);
        end
    end

    // Pointer register, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule : fifo_ptr_counter

// File: rtl/fifo_control.sv
// Pointer, occupancy and flag controller for an external 8-entry FIFO memory.
// Latency: accept strobes are same-cycle; pointers, count, flags follow one cycle later; data_valid is 1 cycle after rd_enable.
// Backpressure: pushes on full (without pop) and pops on empty are dropped and latch the sticky error flag.
module fifo_control
    import fifo_control_pkg::*;
#(
    parameter int ptr_width = PTR_W,
    parameter int af_level  = AF_LEVEL,
    parameter int ae_level  = AE_LEVEL
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    output logic                 wr_enable,
    output logic                 rd_enable,
    output logic [ptr_width-1:0] wr_ptr,
    output logic [ptr_width-1:0] rd_ptr,
    output logic                 data_valid,
    output logic [ptr_width:0]   fifo_count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 error
);

    localparam int depth = 1 << ptr_width;

    logic [ptr_width:0] count_q;
    logic [ptr_width:0] count_d;
    logic               data_valid_q;
    logic               data_valid_d;
    logic               error_q;
    logic               error_d;
    logic               push_ok;
    logic               pop_ok;

    // Flags decode the registered count only, so they trail the accepted operation by one cycle.
    always_comb begin
        full         = (count_q == (ptr_width+1)'(depth));
        empty        = (count_q == '0);
        almost_full  = (count_q >= (ptr_width+1)'(af_level));
        almost_empty = (count_q <= (ptr_width+1)'(ae_level));
    end

    // Accept decision: a full FIFO still takes a push when a pop frees the slot in the same cycle.
    // Strobes are held low during reset so the memory cannot be written while state is clearing.
    always_comb begin
        push_ok = push & (~full | pop) & ~reset;
        pop_ok  = pop & ~empty & ~reset;
    end

    // Next occupancy, read-valid pipeline and sticky error.
    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (ptr_width+1)'(1);
            2'b01:   count_d = count_q - (ptr_width+1)'(1);
            default: count_d = count_q;
        endcase
        data_valid_d = pop_ok;
        error_d      = error_q | (push & ~push_ok) | (pop & ~pop_ok);
    end

    // Occupancy, data_valid and error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q      <= '0;
            data_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            count_q      <= count_d;
            data_valid_q <= data_valid_d;
            error_q      <= error_d;
        end
    end

    fifo_ptr_counter #(
        .ptr_width (ptr_width)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (push_ok),
        .ptr   (wr_ptr)
    );

    fifo_ptr_counter #(
        .ptr_width (ptr_width)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (pop_ok),
        .ptr   (rd_ptr)
    );

    assign wr_enable  = push_ok;
    assign rd_enable  = pop_ok;
    assign fifo_count = count_q;
    assign data_valid = data_valid_q;
    assign error      = error_q;

endmodule : fifo_control

// File: tb/tb_fifo_control.sv
// Self-checking bench for fifo_control with an expected-state scoreboard.
// Latency: expectations for registered outputs are popped one cycle after the stimulus that produced them.
// Backpressure: exercises full/empty rejection paths and the sticky error.
module tb_fifo_control;

    logic       clk;
    logic       reset;
    logic       push;
    logic       pop;
    logic       wr_enable;
    logic       rd_enable;
    logic [2:0] wr_ptr;
    logic [2:0] rd_ptr;
    logic       data_valid;
    logic [3:0] fifo_count;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic       error;

    typedef struct {
        int wr;
        int rd;
        int cnt;
        int dv;
        int err;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp;
    int n_mis;

    // Reference model state
    int m_wr;
    int m_rd;
    int m_cnt;
    int m_dv;
    int m_err;

    fifo_control dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .pop          (pop),
        .wr_enable    (wr_enable),
        .rd_enable    (rd_enable),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .data_valid   (data_valid),
        .fifo_count   (fifo_count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_wr  = 0;
        m_rd  = 0;
        m_cnt = 0;
        m_dv  = 0;
        m_err = 0;
        exp_q.delete();
    endtask

    // Compare every registered output and flag against the oldest expectation.
    task automatic check_regs();
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("wr_ptr",       wr_ptr,       e.wr);
            check("rd_ptr",       rd_ptr,       e.rd);
            check("fifo_count",   fifo_count,   e.cnt);
            check("data_valid",   data_valid,   e.dv);
            check("error",        error,        e.err);
            check("full",         full,         32'(e.cnt == 8));
            check("empty",        empty,        32'(e.cnt == 0));
            check("almost_full",  almost_full,  32'(e.cnt >= 6));
            check("almost_empty", almost_empty, 32'(e.cnt <= 2));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wr_ptr"},    wr_ptr,       0);
        check({tag, "_rd_ptr"},    rd_ptr,       0);
        check({tag, "_count"},     fifo_count,   0);
        check({tag, "_dv"},        data_valid,   0);
        check({tag, "_error"},     error,        0);
        check({tag, "_empty"},     empty,        1);
        check({tag, "_ae"},        almost_empty, 1);
        check({tag, "_full"},      full,         0);
        check({tag, "_af"},        almost_full,  0);
        check({tag, "_wr_en"},     wr_enable,    0);
        check({tag, "_rd_en"},     rd_enable,    0);
    endtask

    // One cycle of stimulus: check last cycle's result, drive, check strobes, queue next expectation.
    task automatic step(input logic p, input logic q);
        bit   pok;
        bit   qok;
        exp_t e;
        @(negedge clk);
        check_regs();
        push = p;
        pop  = q;
        #1;
        pok = p && ((m_cnt != 8) || q);
        qok = q && (m_cnt != 0);
        check("wr_enable", wr_enable, 32'(pok));
        check("rd_enable", rd_enable, 32'(qok));
        m_wr  = (m_wr + int'(pok)) % 8;
        m_rd  = (m_rd + int'(qok)) % 8;
        m_cnt = m_cnt + int'(pok) - int'(qok);
        m_dv  = int'(qok);
        if ((p && !pok) || (q && !qok)) m_err = 1;
        e.wr  = m_wr;
        e.rd  = m_rd;
        e.cnt = m_cnt;
        e.dv  = m_dv;
        e.err = m_err;
        exp_q.push_back(e);
    endtask

    // Asynchronous reset asserted between edges; pending expectations are discarded.
    task automatic apply_reset(input string tag);
        push = 1'b1;
        pop  = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals(tag);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        push  = 1'b0;
        pop   = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_vals({tag, "_rel"});
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        model_clear();
        reset = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;

        // Power-on reset held for two cycles
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;

        // Fill: pointer walks 0..7 and wraps, almost_full at 6, full at 8
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        // Push while full is dropped and sets error
        step(1'b1, 1'b0);
        // Push and pop together while full
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        // Drain to empty
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        // Pop on empty, alone and with a push
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        // Build up to five entries, then reset mid-stream with a read in flight
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        apply_reset("mid");

        // Mixed random traffic, biased towards pushes then pops
        for (int i = 0; i < 60; i++) begin
            if (i < 30) step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0));
            else        step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
        end
        // Flush the final expectation
        step(1'b0, 1'b0);
        @(negedge clk);
        check_regs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_fifo_control
